// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its boot-time program loader.
// Holds the loader state encoding, error codes and the default data/address widths.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } ld_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    // A frame is at most DEPTH payload bytes, at least one
    function automatic logic len_ok(input logic [31:0] n, input int unsigned depth);
        return (n != 32'd0) && (n <= depth);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot loader: takes a framed byte stream (LEN, payload, CSUM) over valid/ready,
// writes the payload into instruction memory from address 0 and releases the CPU.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start             pulse that opens a new frame (from IDLE, RUN or ERR)
//   in_valid/in_data  stream byte offered by the producer
//   in_ready          loader accepts a byte this cycle
//   imem_we/addr/wdata one-cycle instruction memory write
//   cpu_reset         active-high reset to the CPU, low only in RUN
//   busy              frame in progress
//   error/err_code    sticky failure flag and its cause
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // One extra bit so a length of exactly DEPTH is representable
    localparam int CW = ADDR_W + 1;

    ld_state_t         state, state_n;
    logic [CW-1:0]     len, len_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] csum, csum_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [1:0]        ec_n;
    logic              xfer;
    logic              in_frame_n;

    // in_ready is registered from the state, so it always agrees with it
    assign xfer = in_valid && in_ready;

    always_comb begin
        state_n = state;
        len_n   = len;
        cnt_n   = cnt;
        csum_n  = csum;
        we_n    = 1'b0;
        addr_n  = imem_addr;
        wdata_n = imem_wdata;
        ec_n    = err_code;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (len_ok(32'(in_data), DEPTH)) begin
                        len_n   = CW'(in_data);
                        cnt_n   = '0;
                        csum_n  = '0;
                        state_n = S_DATA;
                    end else begin
                        ec_n    = ERR_LEN;
                        state_n = S_ERR;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_n    = 1'b1;
                    addr_n  = cnt[ADDR_W-1:0];
                    wdata_n = in_data;
                    csum_n  = csum ^ in_data;
                    cnt_n   = cnt + 1'b1;
                    if (cnt_n == len) begin
                        state_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (in_data == csum) begin
                        state_n = S_RUN;
                    end else begin
                        ec_n    = ERR_CSUM;
                        state_n = S_ERR;
                    end
                end
            end
            S_RUN, S_ERR: begin
                if (start) begin
                    ec_n    = ERR_NONE;
                    state_n = S_LEN;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign in_frame_n = (state_n == S_LEN) ||
                        (state_n == S_DATA) ||
                        (state_n == S_CSUM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len        <= '0;
            cnt        <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            cpu_reset  <= 1'b1;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_n;
            len        <= len_n;
            cnt        <= cnt_n;
            csum       <= csum_n;
            imem_we    <= we_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
            in_ready   <= in_frame_n;
            busy       <= in_frame_n;
            cpu_reset  <= (state_n != S_RUN);
            error      <= (state_n == S_ERR);
            err_code   <= ec_n;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a per-cycle vector table for the frame
// sequences plus hand-written backpressure and async-reset sequences.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [3:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       error;
    logic [1:0] err_code;

    int tests = 0;
    int fails = 0;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic       cr;
        logic       bz;
        logic       er;
        logic [1:0] ec;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic v, input logic [7:0] d,
                       input logic rdy, input logic we, input logic [3:0] a,
                       input logic [7:0] wd, input logic cr, input logic bz,
                       input logic er, input logic [1:0] ec);
        vec_t t;
        t.st = st; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.a = a;
        t.wd = wd; t.cr = cr; t.bz = bz; t.er = er; t.ec = ec;
        tv.push_back(t);
    endtask

    // One cycle: drive at negedge, sample 1 time unit after the posedge
    task automatic cyc(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = st; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] act, exp;
    int          we_cnt;
    logic        addr_ok;
    logic [7:0]  bp_csum;
    logic [7:0]  bd;

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        chk("reset_outputs",
            {imem_addr, imem_wdata, in_ready, imem_we, cpu_reset, busy, error, err_code},
            {4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
        @(negedge clk);
        reset = 1'b1;

        //  st v  d      rdy we a  wd     cr bz er ec
        // nominal load 03,1A,25,E0, CSUM DF
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h03, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h1A, 1, 1, 0, 8'h1A, 1, 1, 0, 2'b00);
        add(0, 1, 8'h25, 1, 1, 1, 8'h25, 1, 1, 0, 2'b00);
        add(0, 1, 8'hE0, 1, 1, 2, 8'hE0, 1, 1, 0, 2'b00);
        add(0, 1, 8'hDF, 0, 0, 0, 8'h00, 0, 0, 0, 2'b00);
        // reload, same frame with bad CSUM
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h03, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h1A, 1, 1, 0, 8'h1A, 1, 1, 0, 2'b00);
        add(0, 1, 8'h25, 1, 1, 1, 8'h25, 1, 1, 0, 2'b00);
        add(0, 1, 8'hE0, 1, 1, 2, 8'hE0, 1, 1, 0, 2'b00);
        add(0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 2'b10);
        // LEN = 0
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 2'b01);
        // LEN = 17
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0, 1, 2'b01);
        // second frame 01,5F,5F with a gap and a start mid-DATA
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 1, 8'h01, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(0, 0, 8'h77, 1, 0, 0, 8'h00, 1, 1, 0, 2'b00);
        add(1, 1, 8'h5F, 1, 1, 0, 8'h5F, 1, 1, 0, 2'b00);
        add(0, 1, 8'h5F, 0, 0, 0, 8'h00, 0, 0, 0, 2'b00);
        // byte offered in RUN is ignored
        add(0, 1, 8'h03, 0, 0, 0, 8'h00, 0, 0, 0, 2'b00);

        foreach (tv[i]) begin
            cyc(tv[i].st, tv[i].v, tv[i].d);
            if (tv[i].we) begin
                act = {11'd0, in_ready, imem_we, cpu_reset, busy, error, err_code,
                       imem_addr, imem_wdata};
                exp = {11'd0, tv[i].rdy, tv[i].we, tv[i].cr, tv[i].bz, tv[i].er,
                       tv[i].ec, tv[i].a, tv[i].wd};
            end else begin
                act = {25'd0, in_ready, imem_we, cpu_reset, busy, error, err_code};
                exp = {25'd0, tv[i].rdy, tv[i].we, tv[i].cr, tv[i].bz, tv[i].er, tv[i].ec};
            end
            chk($sformatf("vec%0d", i), act, exp);
        end

        // Full-depth load with in_valid toggling every other cycle
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h10);
        we_cnt = 0; addr_ok = 1'b1; bp_csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 8'hAA);
            if (imem_we) begin
                we_cnt++;
                addr_ok = 1'b0;
            end
            bd = 8'(i * 7 + 3);
            bp_csum = bp_csum ^ bd;
            cyc(0, 1, bd);
            if (imem_we) begin
                we_cnt++;
                if (imem_addr != 4'(i) || imem_wdata != bd) addr_ok = 1'b0;
            end
        end
        chk("bp_last_addr", {28'd0, imem_addr}, 32'd15);
        cyc(0, 1, bp_csum);
        if (imem_we) we_cnt++;
        chk("bp_we_pulses", we_cnt, 32'd16);
        chk("bp_addr_seq", {31'd0, addr_ok}, 32'd1);
        chk("bp_run", {29'd0, cpu_reset, in_ready, error}, 32'd0);

        // Async reset in the middle of DATA
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h05);
        cyc(0, 1, 8'h11);
        cyc(0, 1, 8'h22);
        chk("pre_abort_we", {31'd0, imem_we}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("abort_outputs", {28'd0, cpu_reset, in_ready, busy, imem_we}, 32'b1000);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 1, 8'h05);
        chk("idle_after_abort", {29'd0, in_ready, busy, cpu_reset}, 32'b001);
        cyc(1, 0, 8'h00);
        chk("idle_start_len", {30'd0, in_ready, busy}, 32'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader directly upstream of the accumulator CPU.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into the CPU's instruction memory from address 0.
- Verifies an XOR checksum, then releases the CPU from reset so it fetches from PC=0.
- Holds the CPU in reset while loading and on any framing or checksum error.

Parameters:
- ADDR_W, 4, instruction memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction/byte width (4-bit opcode + 4-bit operand).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a new load frame
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle
- imem_addr  out  ADDR_W  instruction memory write address
- imem_wdata  out  DATA_W  instruction memory write data
- cpu_reset  out  1  active-high reset to the CPU core
- busy  out  1  frame in progress (LEN, DATA or CSUM)
- error  out  1  sticky load failure flag
- err_code  out  2  00 none, 01 bad length, 10 checksum mismatch

Behaviour:
- Reset (reset=0, async): state=IDLE; cpu_reset=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; busy=0; error=0; err_code=00; internal count=0; checksum=0. All outputs are registered.
- A transfer occurs only on a clk edge where in_valid && in_ready. Bytes presented while in_ready=0 are ignored; the producer holds them.
- Frame format: LEN byte N, then N payload bytes, then CSUM byte. CSUM must equal the XOR of the N payload bytes.
- IDLE: in_ready=0, cpu_reset=1. A start pulse moves to LEN.
- LEN: in_ready=1, busy=1.
  - On transfer with 1 <= N <= DEPTH: latch N, clear count and checksum, go to DATA.
  - On transfer with N=0 or N>DEPTH: go to ERR with err_code=01.
- DATA: in_ready=1.
  - Each transfer registers imem_we=1, imem_addr=count, imem_wdata=in_data on the next cycle (1-cycle write latency).
  - Each transfer also updates checksum ^= in_data and increments count.
  - After the Nth transfer, go to CSUM.
  - imem_we is never high for more than one cycle per accepted byte.
- CSUM: in_ready=1.
  - On transfer with a match: go to RUN.
  - On transfer with a mismatch: go to ERR with err_code=10.
- RUN: in_ready=0, busy=0. cpu_reset falls on the first cycle in RUN, i.e. the cycle after the CSUM transfer edge.
- ERR: in_ready=0, cpu_reset=1, error=1. Memory contents are undefined.
- start in RUN or ERR: cpu_reset=1 on the next edge; clear error and err_code; go to LEN. This is a reload.
- start during LEN, DATA or CSUM: ignored. The current frame continues.
- The last write (imem_we for the final payload byte) always occurs no later than the CSUM transfer edge, so memory is complete before cpu_reset deasserts.
- Addresses do not wrap: count never exceeds N-1 <= DEPTH-1. N=DEPTH writes addresses 0..DEPTH-1.
- Reset asserted mid-frame aborts immediately to IDLE. Partially written memory is left as is, and the CPU stays in reset.
- No timeout: the loader waits indefinitely for in_valid.

Decomposition:
- Shared package cpu_pkg:
  - loader state enum (IDLE, LEN, DATA, CSUM, RUN, ERR);
  - err_code constants ERR_NONE, ERR_LEN, ERR_CSUM;
  - DATA_W and ADDR_W defaults, shared with the CPU core.
- Single module. No sub-module is warranted; the FSM, counter and checksum register are small enough to sit together.

Test Plan:
- Nominal load: start, bytes 03,1A,25,E0, CSUM=1A^25^E0=DF -> imem writes (0,1A),(1,25),(2,E0); in RUN, cpu_reset=0 one cycle after the CSUM transfer; error=0.
- Checksum fail: same frame with CSUM=00 -> state ERR, error=1, err_code=10, cpu_reset stays 1.
- Bad length: start, LEN=00 -> ERR with err_code=01. Separately, LEN=11 (17) with DEPTH=16 -> ERR with err_code=01. No imem_we pulses in either case.
- Backpressure/gaps: toggle in_valid every other cycle during a DEPTH=16 load -> exactly 16 imem_we pulses at addresses 0..15; address 15 written; RUN reached.
- Reload and ignored start: a start pulse mid-DATA changes nothing. After RUN, start -> cpu_reset=1 next cycle, error cleared; a second frame 01,5F,5F -> address 0=5F, RUN.
- Async reset mid-frame: drop reset during DATA after 2 bytes -> immediately cpu_reset=1, in_ready=0, busy=0, imem_we=0; after release, state is IDLE.
